// File: rtl/osfm_pkg.sv
// Shared types and geometry helpers for the OSFM/JFM partial-product reorder stage.
// Geometry is derived from the operand width, so no per-width tables are needed.
package osfm_pkg;

   typedef enum logic [1:0] {
      MODE_EXACT = 2'd0,
      MODE_ROUND = 2'd1,
      MODE_SHIFT = 2'd2,
      MODE_JFM   = 2'd3
   } mode_e;

   function automatic int rows(input int bw);
      return bw / 2;
   endfunction

   function automatic int ncol(input int bw);
      return 2 * bw;
   endfunction

   function automatic int depth(input int bw);
      return bw / 2 + 3;
   endfunction

   // Slots above the partial-product rows: correction, constant ones, rounding.
   function automatic int slot_corr(input int r);
      return r;
   endfunction

   function automatic int slot_one(input int r);
      return r + 1;
   endfunction

   function automatic int slot_rnd(input int r);
      return r + 2;
   endfunction

endpackage

// File: rtl/osfm_reorder_map.sv
// Combinational mapping of one beat (rows, correction bits, hint, mode) onto the
// column-major pyramid consumed by the compressor tree.
module osfm_reorder_map
   import osfm_pkg::*;
#(
   parameter int BITWIDTH   = 8,
   parameter int TRUNC_COLS = 0,
   parameter int SHIFT_DIST = 1,
   localparam int ROWS  = rows(BITWIDTH),
   localparam int NCOL  = ncol(BITWIDTH),
   localparam int DEPTH = depth(BITWIDTH)
) (
   input  logic [ROWS-1:0][BITWIDTH:0]  pp_array,
   input  logic [ROWS-1:0]              corr,
   input  logic [1:0]                   shift_possible,
   input  mode_e                        mode,
   output logic [NCOL-1:0][DEPTH-1:0]   pp_reord
);

   localparam int SLOT_CORR = slot_corr(ROWS);
   localparam int SLOT_ONE  = slot_one(ROWS);
   localparam int SLOT_RND  = slot_rnd(ROWS);

   logic [NCOL-1:0][DEPTH-1:0] body;
   logic [NCOL-1:0]            rnd;

   always_comb begin
      body = '0;
      for (int i = 0; i < ROWS; i++) begin
         for (int j = 0; j <= BITWIDTH; j++) begin
            body[j+2*i][i] = pp_array[i][j];
         end
         body[2*i][SLOT_CORR] = corr[i] & (mode != MODE_JFM);
      end
      // Sign-extension constants for the Booth rows.
      body[BITWIDTH][SLOT_ONE] = 1'b1;
      for (int i = 0; i < ROWS - 1; i++) begin
         body[BITWIDTH+1+2*i][SLOT_ONE] = 1'b1;
      end
      for (int c = 0; c < TRUNC_COLS; c++) begin
         body[c] = '0;
      end

      rnd = '0;
      case (mode)
         MODE_ROUND, MODE_JFM: rnd[BITWIDTH-1] = 1'b1;
         MODE_SHIFT: begin
            rnd[BITWIDTH-1-SHIFT_DIST] = ~(shift_possible[1] | shift_possible[0]);
            rnd[BITWIDTH-1]            = shift_possible[1] ^ shift_possible[0];
            rnd[BITWIDTH-1+SHIFT_DIST] = shift_possible[1] & shift_possible[0];
         end
         default: ;
      endcase

      // Rounding bits sit outside the truncated region and bypass the mask.
      pp_reord = body;
      for (int c = 0; c < NCOL; c++) begin
         pp_reord[c][SLOT_RND] = rnd[c];
      end
   end

endmodule

// File: rtl/osfm_reorder_pipe.sv
// Registered reorder stage: maps each accepted beat and buffers it in a
// two-entry (output + skid) valid/ready pipeline with one cycle of latency.
module osfm_reorder_pipe
   import osfm_pkg::*;
#(
   parameter int BITWIDTH   = 8,
   parameter int TRUNC_COLS = 0,
   parameter int SHIFT_DIST = 1,
   localparam int ROWS  = rows(BITWIDTH),
   localparam int NCOL  = ncol(BITWIDTH),
   localparam int DEPTH = depth(BITWIDTH)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [ROWS-1:0][BITWIDTH:0]  pp_array,
   input  logic [ROWS-1:0]              corr,
   input  logic [1:0]                   shift_possible,
   input  logic [1:0]                   mode,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NCOL-1:0][DEPTH-1:0]   pp_reord
);

   logic [NCOL-1:0][DEPTH-1:0] mapped;
   logic [NCOL-1:0][DEPTH-1:0] skid;
   logic                       skid_full;
   logic                       accept;
   logic                       drain;
   logic                       skid_full_nxt;

   osfm_reorder_map #(
      .BITWIDTH   (BITWIDTH),
      .TRUNC_COLS (TRUNC_COLS),
      .SHIFT_DIST (SHIFT_DIST)
   ) u_map (
      .pp_array       (pp_array),
      .corr           (corr),
      .shift_possible (shift_possible),
      .mode           (mode_e'(mode)),
      .pp_reord       (mapped)
   );

   // Handshake: a beat enters on in_valid & in_ready and leaves on
   // out_valid & out_ready; in_ready is registered as "skid not full next cycle".
   assign accept        = in_valid & in_ready;
   assign drain         = out_valid & out_ready;
   assign skid_full_nxt = skid_full ? ~drain : (accept & out_valid & ~drain);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pp_reord  <= '0;
         out_valid <= 1'b0;
         skid      <= '0;
         skid_full <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         if (skid_full) begin
            if (drain) begin
               pp_reord  <= skid;
               skid_full <= 1'b0;
            end
         end else if (accept) begin
            if (!out_valid || drain) begin
               pp_reord  <= mapped;
               out_valid <= 1'b1;
            end else begin
               skid      <= mapped;
               skid_full <= 1'b1;
            end
         end else if (drain) begin
            out_valid <= 1'b0;
         end
         in_ready <= ~skid_full_nxt;
      end
   end

endmodule
